// File: rtl/pipe2_skid_buffer.sv
// pipe2_skid_buffer: 2-entry valid/ready skid buffer for the stage-2 bus; optional flush via PIPE2_FLUSH_EN
module pipe2_skid_buffer #(
    parameter int WIDTH = 23
) (
    input  logic             clk,
    input  logic             reset,
`ifdef PIPE2_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_q, skid_q, main_d, skid_d;
    logic             in_xfer, out_xfer;
    // Handshake outputs come straight from the state flops; the encoding equals the beat count
    always_comb begin
        in_ready  = state != FULL;
        out_valid = state != EMPTY;
        occupancy = state;
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
    end
    // Next state and storage updates; skid only fills when main is stalled
    always_comb begin
        state_nxt = state;
        main_d    = main_q;
        skid_d    = skid_q;
        case (state)
            EMPTY: if (in_xfer) begin
                main_d    = din;
                state_nxt = BUSY;
            end
            BUSY: if (in_xfer && out_xfer) begin
                main_d = din;
            end else if (in_xfer) begin
                skid_d    = din;
                state_nxt = FULL;
            end else if (out_xfer) begin
                state_nxt = EMPTY;
            end
            FULL: if (out_xfer) begin
                main_d    = skid_q;
                state_nxt = BUSY;
            end
            default: state_nxt = EMPTY;
        endcase
`ifdef PIPE2_FLUSH_EN
        if (flush) begin
            state_nxt = EMPTY;
            main_d    = '0;
            skid_d    = '0;
        end
`endif
    end
    // State and data registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end
    assign dout = main_q;
endmodule

// File: tb/tb_pipe2_skid_buffer.sv
// tb_pipe2_skid_buffer: scoreboard bench for pipe2_skid_buffer
module tb_pipe2_skid_buffer;
    localparam int W = 23;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] din, dout;
    logic [1:0]   occupancy;
`ifdef PIPE2_FLUSH_EN
    logic         flush = 1'b0;
`endif
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] q[$];

    pipe2_skid_buffer #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
`ifdef PIPE2_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .din(din),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout(dout),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the queue model, then apply this cycle's handshakes and clock once
    task automatic cycle();
        bit ix, ox;
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() != 0) chk("dout", 32'(dout), 32'(q[0]));
        ix = in_valid && (q.size() < 2);
        ox = out_ready && (q.size() != 0);
`ifdef PIPE2_FLUSH_EN
        if (flush) begin
            ix = 0;
            ox = 0;
            q.delete();
        end
`endif
        if (ox) void'(q.pop_front());
        if (ix) q.push_back(din);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 0;
        out_ready = 1;
        for (int i = 0; i < 8 && q.size() != 0; i++) cycle();
        chk("drain_bound", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] held;
        reset = 1; in_valid = 0; out_ready = 0; din = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        reset = 0;

        // back-to-back stream at full throughput
        out_ready = 1; in_valid = 1;
        din = 23'h000001; cycle();
        din = 23'h7FFFFF; cycle();
        din = 23'h2AAAAA; cycle();
        in_valid = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("empty_keeps_dout", 32'(dout), 32'h2AAAAA);

        // stall fill then drain in order
        out_ready = 0; in_valid = 1;
        din = 23'h012345; cycle();
        din = 23'h054321; cycle();
        in_valid = 0;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_dout_held", 32'(dout), 32'h012345);
        cycle();
        drain();

        // FULL with a pending beat held on din
        out_ready = 0; in_valid = 1;
        din = 23'h012345; cycle();
        din = 23'h054321; cycle();
        din = 23'h111111; cycle(); cycle();
        out_ready = 1; cycle(); cycle();
        in_valid = 0;
        chk("pending_after_b", 32'(dout), 32'h111111);
        drain();

        // async reset while FULL
        out_ready = 0; in_valid = 1;
        din = 23'h0AAAAA; cycle();
        din = 23'h055555; cycle();
        in_valid = 0;
        #2 reset = 1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_occupancy", 32'(occupancy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        #2 reset = 0;
        in_valid = 1; din = 23'h000ABC; cycle();
        in_valid = 0;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_dout", 32'(dout), 32'h000ABC);
        drain();

        // random traffic with stall-stability check
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            din       = W'($urandom);
            held      = dout;
            if (out_valid && !out_ready) begin
                cycle();
                chk("stall_stable", 32'(dout), 32'(held));
            end else begin
                cycle();
            end
        end
        drain();

`ifdef PIPE2_FLUSH_EN
        // flush while FULL drops everything including the offered beat
        out_ready = 0; in_valid = 1;
        din = 23'h0CCCCC; cycle();
        din = 23'h033333; cycle();
        din = 23'h0F0F0F; flush = 1; cycle();
        flush = 0; in_valid = 0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_occupancy", 32'(occupancy), 32'd0);
        chk("flush_dout", 32'(dout), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1;
        for (int i = 0; i < 4; i++) cycle();
        in_valid = 1; din = 23'h000123; cycle();
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
